// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Groups the byte-stream handshake and the imem write port of the
//   instruction-memory loader.
//   Stream : in_valid, in_data (producer -> loader), in_ready (loader -> producer)
//   Memory : mem_we, mem_addr, mem_wdata (loader -> imem)
//   Modports: master = stream producer / imem side, slave = the loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Byte-stream programmer for the instruction memory. Receives a frame
//   LEN_LO, LEN_HI (word count N), 4*N data bytes (little-endian words) and
//   an XOR checksum of the data bytes, and writes each word to imem.
//   The core is held in reset while a load is in progress, and after a
//   failed load until the next start or reset.
// Ports
//   clk, reset : clock, synchronous active-high reset
//   start      : begin a load (sampled in IDLE only)
//   bus        : stream handshake + imem write port (slave modport)
//   cpu_hold   : hold the core in reset
//   busy       : load in progress
//   done       : sticky, last load completed with a good checksum
//   err        : sticky, last load failed (length, checksum or timeout)
module imem_loader #(
  parameter int DEPTH_WORDS    = 64,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5
  } state_t;

  state_t      state_r;
  logic [15:0] len_r;
  logic [15:0] word_idx_r;
  logic [1:0]  byte_idx_r;
  logic [7:0]  csum_r;
  logic [31:0] idle_cnt_r;

  logic        accept_s;
  logic [15:0] len_full_s;
  logic        len_bad_s;
  logic        timeout_s;

  // Running checksum: XOR of every data byte.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Handshake, length check and idle-timeout decode.
  assign accept_s   = bus.in_valid & bus.in_ready;
  assign len_full_s = {bus.in_data, len_r[7:0]};
  assign len_bad_s  = ({16'd0, len_full_s} > 32'(DEPTH_WORDS));
  // Fires on the cycle whose edge would make the idle count reach the limit.
  assign timeout_s  = (TIMEOUT_CYCLES != 0) && (idle_cnt_r == 32'(TIMEOUT_CYCLES - 1));

  // Load FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      len_r         <= 16'd0;
      word_idx_r    <= 16'd0;
      byte_idx_r    <= 2'd0;
      csum_r        <= 8'd0;
      idle_cnt_r    <= 32'd0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      cpu_hold      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          bus.in_ready <= 1'b0;
          bus.mem_we   <= 1'b0;
          if (start) begin
            state_r      <= S_LEN_LO;
            bus.in_ready <= 1'b1;
            cpu_hold     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            word_idx_r   <= 16'd0;
            byte_idx_r   <= 2'd0;
            csum_r       <= 8'd0;
            idle_cnt_r   <= 32'd0;
          end else begin
            idle_cnt_r <= 32'd0;
          end
        end

        S_LEN_LO: begin
          if (accept_s) begin
            len_r[7:0] <= bus.in_data;
            idle_cnt_r <= 32'd0;
            state_r    <= S_LEN_HI;
          end else if (timeout_s) begin
            err          <= 1'b1;
            busy         <= 1'b0;
            bus.in_ready <= 1'b0;
            idle_cnt_r   <= 32'd0;
            state_r      <= S_IDLE;
          end else begin
            idle_cnt_r <= idle_cnt_r + 32'd1;
          end
        end

        S_LEN_HI: begin
          if (accept_s) begin
            len_r[15:8] <= bus.in_data;
            idle_cnt_r  <= 32'd0;
            if (len_bad_s) begin
              err          <= 1'b1;
              busy         <= 1'b0;
              bus.in_ready <= 1'b0;
              state_r      <= S_IDLE;
            end else if (len_full_s == 16'd0) begin
              state_r <= S_CSUM;
            end else begin
              state_r <= S_DATA;
            end
          end else if (timeout_s) begin
            err          <= 1'b1;
            busy         <= 1'b0;
            bus.in_ready <= 1'b0;
            idle_cnt_r   <= 32'd0;
            state_r      <= S_IDLE;
          end else begin
            idle_cnt_r <= idle_cnt_r + 32'd1;
          end
        end

        S_DATA: begin
          if (accept_s) begin
            bus.mem_wdata[{byte_idx_r, 3'b000} +: 8] <= bus.in_data;
            csum_r     <= csum_next(csum_r, bus.in_data);
            byte_idx_r <= byte_idx_r + 2'd1;
            idle_cnt_r <= 32'd0;
            if (byte_idx_r == 2'd3) begin
              // Word complete: present it to imem for exactly one cycle.
              state_r      <= S_WRITE;
              bus.in_ready <= 1'b0;
              bus.mem_we   <= 1'b1;
              bus.mem_addr <= {14'd0, word_idx_r, 2'b00};
            end else begin
              state_r <= S_DATA;
            end
          end else if (timeout_s) begin
            err          <= 1'b1;
            busy         <= 1'b0;
            bus.in_ready <= 1'b0;
            idle_cnt_r   <= 32'd0;
            state_r      <= S_IDLE;
          end else begin
            idle_cnt_r <= idle_cnt_r + 32'd1;
          end
        end

        S_WRITE: begin
          bus.mem_we   <= 1'b0;
          bus.in_ready <= 1'b1;
          word_idx_r   <= word_idx_r + 16'd1;
          idle_cnt_r   <= 32'd0;
          if (word_idx_r == (len_r - 16'd1)) begin
            state_r <= S_CSUM;
          end else begin
            state_r <= S_DATA;
          end
        end

        S_CSUM: begin
          if (accept_s) begin
            if (bus.in_data == csum_r) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              // Core stays held so it never runs a corrupt image.
              err <= 1'b1;
            end
            busy         <= 1'b0;
            bus.in_ready <= 1'b0;
            idle_cnt_r   <= 32'd0;
            state_r      <= S_IDLE;
          end else if (timeout_s) begin
            err          <= 1'b1;
            busy         <= 1'b0;
            bus.in_ready <= 1'b0;
            idle_cnt_r   <= 32'd0;
            state_r      <= S_IDLE;
          end else begin
            idle_cnt_r <= idle_cnt_r + 32'd1;
          end
        end

        default: begin
          state_r      <= S_IDLE;
          bus.in_ready <= 1'b0;
          bus.mem_we   <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
